// File: rtl/rng_sampler.sv
// Von Neumann debiasing sampler with rejection to a uniform value on [0, LIMIT-1].
// Optional stuck-source health monitor enabled with `define RNG_HEALTH_EN.
module rng_sampler #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LIMIT     = 10,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned STUCK_LEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_bit,
  input  logic             raw_valid,
  input  logic             start,
  input  logic             ack,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             busy,
  output logic             timeout,
  output logic             health_fail
);

  localparam int unsigned PCW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam int unsigned BCW = $clog2(WIDTH + 1);

  if (LIMIT == 0 || STUCK_LEN == 0 || WIDTH < 2) begin : g_param_check
    $error("rng_sampler: illegal parameter set");
  end

  typedef enum logic [2:0] {IDLE, FIRST, SECOND, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic             a_q, a_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [BCW-1:0]   bit_q, bit_d, bit_inc;
  logic [PCW-1:0]   pair_q, pair_d, pair_sat;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic             hf;
  logic             abort;

  assign bit_inc  = bit_q + 1'b1;
  assign pair_sat = (pair_q == '1) ? pair_q : pair_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    acc_d     = acc_q;
    bit_d     = bit_q;
    pair_d    = pair_q;
    value_d   = value_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (hf) begin
            abort = 1'b1;
          end else begin
            state_d = FIRST;
            bit_d   = '0;
            pair_d  = '0;
            acc_d   = '0;
          end
        end
      end
      FIRST: begin
        if (hf) begin
          abort = 1'b1;
        end else if (raw_valid) begin
          a_d     = raw_bit;
          state_d = SECOND;
        end
      end
      SECOND: begin
        if (hf) begin
          abort = 1'b1;
        end else if (raw_valid) begin
          pair_d = pair_sat;
          if (a_q != raw_bit) begin
            acc_d = {acc_q[WIDTH-2:0], a_q};
            bit_d = bit_inc;
          end
          // Finishing the last bit takes priority over an expiring pair budget.
          if (a_q != raw_bit && 32'(bit_inc) == WIDTH) begin
            state_d = CHECK;
          end else if (32'(pair_sat) >= TIMEOUT) begin
            abort = 1'b1;
          end else begin
            state_d = FIRST;
          end
        end
      end
      CHECK: begin
        if (32'(acc_q) < LIMIT) begin
          value_d   = acc_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          state_d   = DONE;
        end else begin
          bit_d   = '0;
          acc_d   = '0;
          state_d = FIRST;
        end
      end
      DONE: begin
        if (ack) begin
          valid_d   = 1'b0;
          timeout_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = DONE;
      value_d   = '0;
      valid_d   = 1'b1;
      timeout_d = 1'b1;
    end
    busy_d = (state_d == FIRST) || (state_d == SECOND) || (state_d == CHECK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_q       <= 1'b0;
      acc_q     <= '0;
      bit_q     <= '0;
      pair_q    <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      bit_q     <= bit_d;
      pair_q    <= pair_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef RNG_HEALTH_EN
  localparam int unsigned RCW = $clog2(STUCK_LEN + 1);

  logic           last_q;
  logic [RCW-1:0] run_q, run_d;
  logic           hf_q;

  // Run length of identical samples, tracked in every state; 0 means no sample yet.
  always_comb begin
    run_d = run_q;
    if (raw_valid) begin
      if (run_q != '0 && raw_bit == last_q) begin
        run_d = (run_q == '1) ? run_q : run_q + 1'b1;
      end else begin
        run_d = RCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b0;
      run_q  <= '0;
      hf_q   <= 1'b0;
    end else begin
      if (raw_valid) begin
        last_q <= raw_bit;
      end
      run_q <= run_d;
      if (32'(run_d) >= STUCK_LEN) begin
        hf_q <= 1'b1;
      end
    end
  end

  assign hf = hf_q;
`else
  assign hf = 1'b0;
`endif

  assign value       = value_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign timeout     = timeout_q;
  assign health_fail = hf;

endmodule

// File: tb/tb_rng_sampler.sv
// Bench for rng_sampler: directed vector table, randomized streams against a stream-level model,
// hold/ack, mid-request reset and stuck-source cases.
module tb_rng_sampler;

  localparam int WIDTH   = 4;
  localparam int LIMIT   = 10;
  localparam int TIMEOUT = 255;
  localparam int MAXC    = 1024;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             raw_bit = 1'b0;
  logic             raw_valid = 1'b0;
  logic             start = 1'b0;
  logic             ack = 1'b0;
  logic [WIDTH-1:0] value;
  logic             valid;
  logic             busy;
  logic             timeout;
  logic             health_fail;

  int errors = 0;
  int checks = 0;

  bit rv [MAXC];
  bit rb [MAXC];

  typedef struct {
    string      name;
    string      pat;
    logic [3:0] val;
    int         lat;
    bit         to;
  } vec_t;

  vec_t vt [6];

  rng_sampler #(
    .WIDTH    (WIDTH),
    .LIMIT    (LIMIT),
    .TIMEOUT  (TIMEOUT),
    .STUCK_LEN(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_bit    (raw_bit),
    .raw_valid  (raw_valid),
    .start      (start),
    .ack        (ack),
    .value      (value),
    .valid      (valid),
    .busy       (busy),
    .timeout    (timeout),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input string s);
    for (int c = 0; c < MAXC; c++) begin
      rv[c] = (c >= 1) && (c <= s.len());
      rb[c] = rv[c] && (s[c-1] == 8'h31);
    end
  endtask

  // Walks the sample stream offered after the start edge: pairs of accepted samples,
  // unequal pairs yield the first bit, a full word costs one extra cycle to judge.
  function automatic void model(output int lat, output logic [3:0] val, output bit to);
    int acc = 0;
    int nb = 0;
    int pairs = 0;
    bit have_a = 0;
    bit a = 0;
    bit judge = 0;
    lat = -1;
    val = '0;
    to  = 0;
    for (int c = 1; c < MAXC; c++) begin
      if (judge) begin
        judge = 0;
        if (acc < LIMIT) begin
          lat = c;
          val = 4'(acc);
          return;
        end
        acc = 0;
        nb  = 0;
        continue;
      end
      if (!rv[c]) continue;
      if (!have_a) begin
        a = rb[c];
        have_a = 1;
        continue;
      end
      have_a = 0;
      if (pairs < 255) pairs++;
      if (a != rb[c]) begin
        acc = acc * 2 + int'(a);
        nb++;
        if (nb == WIDTH) begin
          judge = 1;
          continue;
        end
      end
      if (pairs >= TIMEOUT) begin
        lat = c;
        to  = 1;
        return;
      end
    end
  endfunction

  // exp_lat < 0 skips the latency comparison; hold > 0 keeps DONE for that many cycles.
  task automatic do_req(input string name, input int exp_lat, input logic [3:0] exp_val,
                        input bit exp_to, input int hold);
    int lat = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c < MAXC && lat < 0; c++) begin
      raw_valid = rv[c];
      raw_bit   = rb[c];
      @(posedge clk);
      #1;
      if (c == 1) chk({name, " busy_run"}, int'(busy), 1);
      if (valid) lat = c;
    end
    raw_valid = 1'b0;
    if (lat < 0) chk({name, " no_valid_within_budget"}, lat, exp_lat);
    else if (exp_lat >= 0) chk({name, " latency"}, lat, exp_lat);
    chk({name, " value"}, int'(value), int'(exp_val));
    chk({name, " timeout"}, int'(timeout), int'(exp_to));
    chk({name, " busy_done"}, int'(busy), 0);
    for (int h = 0; h < hold; h++) begin
      start = h[0];
      @(posedge clk);
      #1;
      chk({name, " hold_valid"}, int'(valid), 1);
      chk({name, " hold_value"}, int'(value), int'(exp_val));
    end
    ack   = 1'b1;
    start = (hold > 0);
    @(posedge clk);
    #1;
    ack   = 1'b0;
    start = 1'b0;
    chk({name, " ack_valid"}, int'(valid), 0);
    chk({name, " ack_timeout"}, int'(timeout), 0);
    chk({name, " ack_value_kept"}, int'(value), int'(exp_val));
    if (hold > 0) begin
      @(posedge clk);
      #1;
      chk({name, " start_with_ack_ignored"}, int'(busy), 0);
    end
  endtask

  initial begin
    int lat;
    logic [3:0] mv;
    bit mto;

    vt[0] = '{"plain_2",     "01011001",          4'd2, 9,  1'b0};
    vt[1] = '{"reject_11",   "10011010001011001", 4'd2, 18, 1'b0};
    vt[2] = '{"discard",     "010001111001",      4'd2, 13, 1'b0};
    vt[3] = '{"limit_m1",    "10010110",          4'd9, 9,  1'b0};
    vt[4] = '{"zero",        "01010101",          4'd0, 9,  1'b0};
    vt[5] = '{"reject_lim",  "10011001010010110", 4'd9, 18, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_value", int'(value), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_timeout", int'(timeout), 0);
    chk("reset_health", int'(health_fail), 0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      load(vt[i].pat);
      do_req(vt[i].name, vt[i].lat, vt[i].val, vt[i].to, 0);
    end

    load("10010110");
    do_req("hold", 9, 4'd9, 1'b0, 5);

    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < MAXC; c++) begin
        rv[c] = ($urandom_range(0, 3) != 0);
        rb[c] = 1'($urandom_range(0, 1));
      end
      model(lat, mv, mto);
      do_req($sformatf("rand%0d", r), lat, mv, mto, 0);
    end

    // Reset in SECOND after two good bits, then a clean request.
    load("01010");
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      raw_valid = rv[c];
      raw_bit   = rb[c];
      @(posedge clk);
      #1;
    end
    chk("midreset_busy_before", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_valid", int'(valid), 0);
    chk("midreset_value", int'(value), 0);
    chk("midreset_timeout", int'(timeout), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      raw_valid = 1'b1;
      raw_bit   = c[0];
      @(posedge clk);
      #1;
      chk("post_reset_no_valid", int'(valid), 0);
    end
    raw_valid = 1'b0;
    load("01011001");
    do_req("after_reset", 9, 4'd2, 1'b0, 0);

    for (int c = 0; c < MAXC; c++) begin
      rv[c] = 1'b1;
      rb[c] = 1'b1;
    end
`ifdef RNG_HEALTH_EN
    do_req("stuck", -1, 4'd0, 1'b1, 0);
    chk("stuck_health", int'(health_fail), 1);
`else
    do_req("stuck", 2 * TIMEOUT, 4'd0, 1'b1, 0);
    chk("stuck_health", int'(health_fail), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
